// File: rtl/dmem_wbuf.sv
// Data-memory stage: stores enter a small coalescing write buffer that drains
// into a slow word RAM; loads merge RAM data with byte-accurate forwarding.
module dmem_wbuf #(
  parameter int ADDR_W    = 6,
  parameter int DEPTH     = 4,
  parameter int DRAIN_LAT = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic                     sb,
  input  logic [31:0]              addr,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic                     stall,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = (DRAIN_LAT > 1) ? $clog2(DRAIN_LAT) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [31:0]       data;
    logic [3:0]        be;
  } ent_t;

  ent_t              ent_q [DEPTH];
  ent_t              ent_d [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d, yng;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [31:0]       mem_q [2**ADDR_W];

  logic [ADDR_W-1:0] widx;
  logic [1:0]        bsel;
  logic [3:0]        new_be;
  logic [31:0]       new_data, new_mask;
  logic              drain_fire, coalesce, full, alloc;
  logic              unused_addr;

  assign widx        = addr[ADDR_W+1:2];
  assign bsel        = addr[1:0];
  assign unused_addr = ^addr[31:ADDR_W+2];
  assign new_be      = sb ? (4'b0001 << bsel) : 4'b1111;
  assign new_data    = sb ? {4{writedata[7:0]}} : writedata;
  assign new_mask    = {{8{new_be[3]}}, {8{new_be[2]}}, {8{new_be[1]}}, {8{new_be[0]}}};

  assign yng         = tail_q - PW'(1);
  assign full        = (cnt_q == CW'(DEPTH));
  assign drain_fire  = (cnt_q != '0) && (dcnt_q == DW'(DRAIN_LAT - 1));
  // The youngest entry is also the draining one only when it is the sole entry.
  assign coalesce    = memwrite && (cnt_q != '0) && (ent_q[yng].idx == widx) &&
                       !(drain_fire && (cnt_q == CW'(1)));
  assign alloc       = memwrite && !coalesce && (!full || drain_fire);
  assign stall       = memwrite && !coalesce && full && !drain_fire;
  assign empty       = (cnt_q == '0);
  assign count       = cnt_q;

  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    dcnt_d = (empty || drain_fire) ? '0 : dcnt_q + DW'(1);
    if (coalesce) begin
      ent_d[yng].data = (ent_q[yng].data & ~new_mask) | (new_data & new_mask);
      ent_d[yng].be   = ent_q[yng].be | new_be;
    end
    if (alloc) begin
      ent_d[tail_q].idx  = widx;
      ent_d[tail_q].data = new_data;
      ent_d[tail_q].be   = new_be;
      tail_d             = tail_q + PW'(1);
    end
    if (drain_fire) head_d = head_q + PW'(1);
    case ({alloc, drain_fire})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      dcnt_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      dcnt_q <= dcnt_d;
    end
  end

  // Payload and RAM are not reset; held in reset, count=0 blocks any drain.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
    if (drain_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (ent_q[head_q].be[b])
          mem_q[ent_q[head_q].idx][8*b +: 8] <= ent_q[head_q].data[8*b +: 8];
      end
    end
  end

  // Oldest-to-youngest walk so the newest pending byte wins.
  always_comb begin
    readdata = mem_q[widx];
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < cnt_q) && (ent_q[head_q + PW'(k)].idx == widx)) begin
        for (int b = 0; b < 4; b++) begin
          if (ent_q[head_q + PW'(k)].be[b])
            readdata[8*b +: 8] = ent_q[head_q + PW'(k)].data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf: vector tables plus hand sequences for
// drain waits, address aliasing and asynchronous reset mid-drain.
module tb_dmem_wbuf;

  logic        clk = 0;
  logic        reset;
  logic        memwrite, sb;
  logic [31:0] addr, writedata, readdata;
  logic        stall, empty;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  dmem_wbuf #(.ADDR_W(6), .DEPTH(4), .DRAIN_LAT(3)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .sb(sb), .addr(addr),
    .writedata(writedata), .readdata(readdata), .stall(stall), .empty(empty),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mw;
    logic        sb;
    logic [31:0] a;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] rd;
    logic        stl;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t V(logic mw, logic s, logic [31:0] a, logic [31:0] wd,
                             logic cr, logic [31:0] rd, logic stl, logic [2:0] cnt);
    vec_t v;
    v.mw = mw; v.sb = s; v.a = a; v.wd = wd;
    v.chk_rd = cr; v.rd = rd; v.stl = stl; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle();
    memwrite = 0; sb = 0; writedata = 0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic apply_tbl(input string tag);
    foreach (vt[i]) begin
      memwrite = vt[i].mw; sb = vt[i].sb; addr = vt[i].a; writedata = vt[i].wd;
      #1;
      chk($sformatf("%s[%0d].stall", tag, i), {31'b0, stall}, {31'b0, vt[i].stl});
      if (vt[i].chk_rd) chk($sformatf("%s[%0d].readdata", tag, i), readdata, vt[i].rd);
      @(posedge clk); #1;
      chk($sformatf("%s[%0d].count", tag, i), {29'b0, count}, {29'b0, vt[i].cnt});
      chk($sformatf("%s[%0d].empty", tag, i), {31'b0, empty}, {31'b0, vt[i].cnt == 0});
    end
    vt.delete();
    idle();
  endtask

  task automatic wait_empty(input string tag, input int max_cyc);
    int n = 0;
    idle();
    while (!empty && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".drained"}, {31'b0, empty}, 32'd1);
  endtask

  task automatic rd_at(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; #1;
    chk(tag, readdata, exp);
  endtask

  initial begin
    reset = 0; idle(); addr = 0;
    #12;
    chk("reset.count", {29'b0, count}, 32'd0);
    chk("reset.empty", {31'b0, empty}, 32'd1);
    chk("reset.stall", {31'b0, stall}, 32'd0);
    @(negedge clk) reset = 1;
    @(posedge clk); #1;

    // Word store, forwarding, drain after 3 cycles, then byte stores coalescing.
    vt.push_back(V(1,0,32'h10,32'h11223344, 0,32'h0,        0,1));
    vt.push_back(V(0,0,32'h10,32'h0,        1,32'h11223344, 0,1));
    vt.push_back(V(0,0,32'h10,32'h0,        1,32'h11223344, 0,1));
    vt.push_back(V(0,0,32'h10,32'h0,        1,32'h11223344, 0,0));
    vt.push_back(V(0,0,32'h10,32'h0,        1,32'h11223344, 0,0));
    vt.push_back(V(1,1,32'h12,32'h123456AA, 1,32'h11223344, 0,1));
    vt.push_back(V(1,1,32'h13,32'h987654BB, 1,32'h11AA3344, 0,1));
    vt.push_back(V(0,0,32'h10,32'h0,        1,32'hBBAA3344, 0,1));
    vt.push_back(V(0,0,32'h10,32'h0,        1,32'hBBAA3344, 0,0));
    vt.push_back(V(0,0,32'h10,32'h0,        1,32'hBBAA3344, 0,0));
    // Back-to-back word stores: first drain overlaps the 4th, 6th stalls once
    // and is accepted on the drain cycle with count held at DEPTH.
    vt.push_back(V(1,0,32'h40,32'hA0A00000, 0,32'h0, 0,1));
    vt.push_back(V(1,0,32'h44,32'hA0A00001, 0,32'h0, 0,2));
    vt.push_back(V(1,0,32'h48,32'hA0A00002, 0,32'h0, 0,3));
    vt.push_back(V(1,0,32'h4C,32'hA0A00003, 0,32'h0, 0,3));
    vt.push_back(V(1,0,32'h50,32'hA0A00004, 0,32'h0, 0,4));
    vt.push_back(V(1,0,32'h54,32'hA0A00005, 0,32'h0, 1,4));
    vt.push_back(V(1,0,32'h54,32'hA0A00005, 0,32'h0, 0,4));
    vt.push_back(V(0,0,32'h54,32'h0,        1,32'hA0A00005, 0,4));
    apply_tbl("seq");
    wait_empty("burst", 20);
    for (int i = 0; i < 6; i++)
      rd_at($sformatf("burst.ram%0d", i), 32'h40 + 4*i, 32'hA0A00000 | i);

    // Same word split by another word: no coalesce, youngest forwards last.
    vt.push_back(V(1,0,32'h20,32'h1, 0,32'h0, 0,1));
    vt.push_back(V(1,0,32'h24,32'h2, 0,32'h0, 0,2));
    vt.push_back(V(1,0,32'h20,32'h3, 1,32'h1, 0,3));
    vt.push_back(V(0,0,32'h20,32'h0, 1,32'h3, 0,2));
    apply_tbl("nocoal");
    wait_empty("nocoal", 20);
    rd_at("nocoal.ram8", 32'h20, 32'h3);
    rd_at("nocoal.ram9", 32'h24, 32'h2);

    // Upper address bits alias onto word 0.
    vt.push_back(V(1,0,32'h100,32'hCAFEF00D, 0,32'h0,        0,1));
    vt.push_back(V(0,0,32'h000,32'h0,        1,32'hCAFEF00D, 0,1));
    apply_tbl("wrap");
    wait_empty("wrap", 20);
    rd_at("wrap.ram0", 32'h000, 32'hCAFEF00D);
    rd_at("wrap.alias", 32'h100, 32'hCAFEF00D);

    // Three pending entries, reset asserted mid-cycle before the first drain.
    vt.push_back(V(1,0,32'h40,32'hD0, 0,32'h0, 0,1));
    vt.push_back(V(1,0,32'h44,32'hD1, 0,32'h0, 0,2));
    vt.push_back(V(1,0,32'h48,32'hD2, 0,32'h0, 0,3));
    apply_tbl("rst");
    #1 reset = 0;
    #1;
    chk("rst.async_count", {29'b0, count}, 32'd0);
    chk("rst.async_empty", {31'b0, empty}, 32'd1);
    #1 reset = 1;
    rd_at("rst.ram16", 32'h40, 32'hA0A00000);
    rd_at("rst.ram17", 32'h44, 32'hA0A00001);
    rd_at("rst.ram18", 32'h48, 32'hA0A00002);
    @(posedge clk); #1;
    chk("rst.count_after", {29'b0, count}, 32'd0);
    rd_at("rst.ram16_after", 32'h40, 32'hA0A00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
